// File: rtl/cpu_sequencer.sv
// Cirno core control sequencer: owns PC and instruction register, fetches over a
// req/ack port, strobes the decoder and steps execute / data-memory phases.
module cpu_sequencer #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic [8:0]       imem_rdata,
    output logic [PC_W-1:0]  pc,
    output logic [8:0]       inst,
    output logic             decoder_en,
    input  logic [2:0]       inst_type,
    input  logic             branch,
    input  logic             branchi,
    input  logic [5:0]       immediate,
    input  logic             done,
    input  logic [PC_W-1:0]  br_target,
    output logic             alu_en,
    output logic             reg_wr_en,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [2:0] T_ALU = 3'd1;
    localparam logic [2:0] T_IBR = 3'd2;
    localparam logic [2:0] T_RBR = 3'd3;
    localparam logic [2:0] T_MOV = 3'd4;
    localparam logic [2:0] T_ST  = 3'd5;
    localparam logic [2:0] T_LD  = 3'd6;
    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    // Retired count sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    state_t            state_r, state_s;
    logic [PC_W-1:0]   pc_r, pc_s;
    logic [8:0]        inst_r, inst_s;
    logic [CNT_W-1:0]  retired_r, retired_s;
    logic              mem_we_r, mem_we_s;
    logic              imem_req_r, dmem_req_r, decoder_en_r, halted_r;
    logic              alu_en_s, reg_wr_en_s;
    logic [PC_W-1:0]   br_off_s;

    assign br_off_s = {{(PC_W-6){immediate[5]}}, immediate};

    // Next-state, PC/retired update and execute-phase strobes
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        inst_s      = inst_r;
        retired_s   = retired_r;
        mem_we_s    = mem_we_r;
        alu_en_s    = 1'b0;
        reg_wr_en_s = 1'b0;
        case (state_r)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_s      = {PC_W{1'b0}};
                    retired_s = {CNT_W{1'b0}};
                    state_s   = S_FETCH;
                end else begin
                    state_s   = state_r;
                end
            end
            S_FETCH: begin
                if (imem_ack) begin
                    inst_s  = imem_rdata;
                    state_s = S_DECODE;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_DECODE: begin
                state_s = S_EXEC;
            end
            S_EXEC: begin
                state_s   = S_FETCH;
                retired_s = sat_inc(retired_r);
                pc_s      = pc_r + PC_ONE;
                case (inst_type)
                    T_ALU: begin
                        alu_en_s    = 1'b1;
                        reg_wr_en_s = 1'b1;
                    end
                    T_MOV: begin
                        reg_wr_en_s = 1'b1;
                    end
                    T_IBR: begin
                        if (done) begin
                            state_s   = S_HALT;
                            pc_s      = pc_r;
                            retired_s = retired_r;
                        end else if (branchi) begin
                            pc_s = pc_r + br_off_s;
                        end else begin
                            pc_s = pc_r + PC_ONE;
                        end
                    end
                    T_RBR: begin
                        if (branch) begin
                            pc_s = br_target;
                        end else begin
                            pc_s = pc_r + PC_ONE;
                        end
                    end
                    T_ST, T_LD: begin
                        // PC and retired advance only when the memory access completes
                        state_s   = S_MEM;
                        pc_s      = pc_r;
                        retired_s = retired_r;
                        mem_we_s  = (inst_type == T_ST);
                    end
                    default: begin
                        pc_s = pc_r + PC_ONE;
                    end
                endcase
            end
            S_MEM: begin
                if (dmem_ack) begin
                    pc_s        = pc_r + PC_ONE;
                    retired_s   = sat_inc(retired_r);
                    reg_wr_en_s = ~mem_we_r;
                    state_s     = S_FETCH;
                end else begin
                    state_s     = S_MEM;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // State, architectural registers and request/strobe flops keyed off the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_IDLE;
            pc_r         <= {PC_W{1'b0}};
            inst_r       <= 9'd0;
            retired_r    <= {CNT_W{1'b0}};
            mem_we_r     <= 1'b0;
            imem_req_r   <= 1'b0;
            dmem_req_r   <= 1'b0;
            decoder_en_r <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            state_r      <= state_s;
            pc_r         <= pc_s;
            inst_r       <= inst_s;
            retired_r    <= retired_s;
            mem_we_r     <= mem_we_s;
            imem_req_r   <= (state_s == S_FETCH);
            dmem_req_r   <= (state_s == S_MEM);
            decoder_en_r <= (state_s == S_DECODE);
            halted_r     <= (state_s == S_HALT);
        end
    end

    assign pc         = pc_r;
    assign inst       = inst_r;
    assign retired    = retired_r;
    assign imem_req   = imem_req_r;
    assign dmem_req   = dmem_req_r;
    assign dmem_we    = dmem_req_r & mem_we_r;
    assign decoder_en = decoder_en_r;
    assign halted     = halted_r;
    assign alu_en     = alu_en_s;
    assign reg_wr_en  = reg_wr_en_s;
endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer: a driver plays instruction memory,
// decoder and data memory; a negedge monitor checks each instruction's footprint.
module tb_cpu_sequencer;
    logic        clk, rst_n, start;
    logic        imem_req, imem_ack;
    logic [8:0]  imem_rdata, inst;
    logic [7:0]  pc, br_target;
    logic        decoder_en, branch, branchi, done;
    logic [2:0]  inst_type;
    logic [5:0]  immediate;
    logic        alu_en, reg_wr_en, dmem_req, dmem_we, dmem_ack, halted;
    logic [15:0] retired;

    cpu_sequencer #(.PC_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .pc(pc), .inst(inst), .decoder_en(decoder_en),
        .inst_type(inst_type), .branch(branch), .branchi(branchi),
        .immediate(immediate), .done(done), .br_target(br_target),
        .alu_en(alu_en), .reg_wr_en(reg_wr_en),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .halted(halted), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] itype;
        logic       br, bri, dn;
        logic [5:0] imm;
        logic [7:0] tgt;
        logic [8:0] word;
        int         iw, dw;
    } instr_t;

    typedef struct {
        int pc, ret, inst, cyc, alu, reg_n, regmem, ireq, dreq, we, post_pc, post_ret, halt;
    } exp_t;

    exp_t   exp_q[$];
    instr_t prog_q[$];
    int     total = 0;
    int     bad = 0;
    int     m_pc = 0;
    int     m_ret = 0;
    bit     aborted = 1'b0;

    task automatic chk(input string nm, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, a, e);
        end
    endtask

    function automatic instr_t mk(input logic [2:0] t, input logic br, input logic bri,
                                  input logic dn, input logic [5:0] imm, input logic [7:0] tgt,
                                  input int iw, input int dw);
        instr_t d;
        d.itype = t; d.br = br; d.bri = bri; d.dn = dn;
        d.imm = imm; d.tgt = tgt; d.iw = iw; d.dw = dw;
        d.word = 9'($urandom);
        return d;
    endfunction

    // Reference: what one instruction should do, from the architectural rules
    function automatic exp_t model(input instr_t d, input int cpc, input int cret);
        exp_t e;
        int   off;
        bit   mem;
        off        = (d.imm > 6'd31) ? int'(d.imm) - 64 : int'(d.imm);
        mem        = (d.itype == 3'd5) || (d.itype == 3'd6);
        e.pc       = cpc;
        e.ret      = cret;
        e.inst     = int'(d.word);
        e.halt     = (d.itype == 3'd2 && d.dn) ? 1 : 0;
        e.cyc      = 3 + d.iw + (mem ? 1 + d.dw : 0);
        e.alu      = (d.itype == 3'd1) ? 1 : 0;
        e.reg_n    = (d.itype == 3'd1 || d.itype == 3'd4 || d.itype == 3'd6) ? 1 : 0;
        e.regmem   = (d.itype == 3'd6) ? 1 : 0;
        e.ireq     = 1 + d.iw;
        e.dreq     = mem ? 1 + d.dw : 0;
        e.we       = (d.itype == 3'd5) ? 1 : 0;
        if (e.halt == 1)                       e.post_pc = cpc;
        else if (d.itype == 3'd2 && d.bri)     e.post_pc = (cpc + off + 256) % 256;
        else if (d.itype == 3'd3 && d.br)      e.post_pc = int'(d.tgt);
        else                                   e.post_pc = (cpc + 1) % 256;
        if (e.halt == 1)                       e.post_ret = cret;
        else                                   e.post_ret = (cret < 65535) ? cret + 1 : cret;
        return e;
    endfunction

    // Monitor: carve the DUT activity into instructions and score each against the queue
    initial begin
        bit   act, pr_req, pr_halt, we_seen;
        int   cyc, n_dec, n_alu, n_reg, n_regmem, n_ireq, n_dreq, s_pc, s_ret, s_inst;
        exp_t e;
        act = 1'b0; pr_req = 1'b0; pr_halt = 1'b0;
        cyc = 0; n_dec = 0; n_alu = 0; n_reg = 0; n_regmem = 0; n_ireq = 0; n_dreq = 0;
        we_seen = 1'b0; s_pc = 0; s_ret = 0; s_inst = 0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                act = 1'b0; pr_req = 1'b0; pr_halt = 1'b0;
            end else begin
                if ((imem_req === 1'b1 && !pr_req) || (halted === 1'b1 && !pr_halt)) begin
                    if (act) begin
                        if (exp_q.size() == 0) begin
                            total++; bad++;
                            $display("FAIL sb_empty: got instruction with no expectation queued");
                        end else begin
                            e = exp_q.pop_front();
                            chk("pc_fetch", s_pc, e.pc);
                            chk("ret_fetch", s_ret, e.ret);
                            chk("inst", s_inst, e.inst);
                            chk("cycles", cyc, e.cyc);
                            chk("dec_pulses", n_dec, 1);
                            chk("alu_pulses", n_alu, e.alu);
                            chk("regwr_pulses", n_reg, e.reg_n);
                            chk("regwr_in_ack", n_regmem, e.regmem);
                            chk("imem_req_cyc", n_ireq, e.ireq);
                            chk("dmem_req_cyc", n_dreq, e.dreq);
                            chk("dmem_we", int'(we_seen), e.we);
                            chk("post_pc", int'(pc), e.post_pc);
                            chk("post_ret", int'(retired), e.post_ret);
                            chk("halted", int'(halted), e.halt);
                        end
                    end
                    act = 1'b0;
                end
                if (imem_req === 1'b1 && !pr_req) begin
                    act = 1'b1; cyc = 0; n_dec = 0; n_alu = 0; n_reg = 0; n_regmem = 0;
                    n_ireq = 0; n_dreq = 0; we_seen = 1'b0;
                    s_pc = int'(pc); s_ret = int'(retired); s_inst = -1;
                end
                if (act) begin
                    cyc++;
                    if (decoder_en === 1'b1) begin n_dec++; s_inst = int'(inst); end
                    if (alu_en === 1'b1) n_alu++;
                    if (reg_wr_en === 1'b1) n_reg++;
                    if (reg_wr_en === 1'b1 && dmem_req === 1'b1 && dmem_ack === 1'b1) n_regmem++;
                    if (imem_req === 1'b1) n_ireq++;
                    if (dmem_req === 1'b1) n_dreq++;
                    if (dmem_req === 1'b1 && dmem_we === 1'b1) we_seen = 1'b1;
                end
                pr_req = (imem_req === 1'b1);
                pr_halt = (halted === 1'b1);
            end
        end
    end

    // Driver for one instruction; with hang set it stops in MEM without acking
    task automatic run_instr(input instr_t d, input bit hang);
        exp_t e;
        int   n;
        if (!hang) begin
            e = model(d, m_pc, m_ret);
            exp_q.push_back(e);
            m_pc = e.post_pc;
            m_ret = e.post_ret;
        end
        n = 0;
        while (imem_req !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (n >= 50) begin
            total++; bad++; aborted = 1'b1;
            $display("FAIL fetch_timeout: got no imem_req want imem_req=1");
            return;
        end
        repeat (d.iw) begin @(posedge clk); #1; end
        imem_ack = 1'b1; imem_rdata = d.word;
        @(posedge clk); #1;
        imem_ack = 1'b0; imem_rdata = 9'($urandom);
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        inst_type = d.itype; branch = d.br; branchi = d.bri; done = d.dn;
        immediate = d.imm; br_target = d.tgt;
        if (d.itype == 3'd5 || d.itype == 3'd6) begin
            @(posedge clk); #1;
            if (hang) return;
            repeat (d.dw) begin @(posedge clk); #1; end
            dmem_ack = 1'b1;
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
    endtask

    task automatic run_prog();
        int n;
        m_pc = 0; m_ret = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        foreach (prog_q[i]) begin
            if (!aborted) run_instr(prog_q[i], 1'b0);
        end
        n = 0;
        while (!aborted && halted !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        if (!aborted && n >= 20) begin
            total++; bad++; aborted = 1'b1;
            $display("FAIL halt_timeout: got halted=0 want halted=1");
        end
        if (!aborted) begin
            repeat (3) begin @(posedge clk); #1; end
            chk("halt_hold", int'(halted), 1);
            chk("halt_noreq", int'(imem_req), 0);
            chk("halt_pc_hold", int'(pc), m_pc);
        end
        prog_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_ack = 1'b0; imem_rdata = 9'd0;
        inst_type = 3'd0; branch = 1'b0; branchi = 1'b0; immediate = 6'd0;
        done = 1'b0; br_target = 8'd0; dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_pc", int'(pc), 0);
        chk("rst_inst", int'(inst), 0);
        chk("rst_retired", int'(retired), 0);
        chk("rst_imem_req", int'(imem_req), 0);
        chk("rst_dmem_req", int'(dmem_req), 0);
        chk("rst_decoder_en", int'(decoder_en), 0);
        chk("rst_alu_en", int'(alu_en), 0);
        chk("rst_reg_wr_en", int'(reg_wr_en), 0);
        chk("rst_halted", int'(halted), 0);

        // Reset while a store is waiting on dmem_ack
        m_pc = 0; m_ret = 0;
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        run_instr(mk(3'd3, 1'b1, 1'b0, 1'b0, 6'd0, 8'h33, 0, 0), 1'b0);
        run_instr(mk(3'd5, 1'b0, 1'b0, 1'b0, 6'd0, 8'h00, 0, 0), 1'b1);
        chk("mid_mem_req", int'(dmem_req), 1);
        chk("mid_mem_we", int'(dmem_we), 1);
        chk("mid_mem_pc", int'(pc), 51);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_dmem_req", int'(dmem_req), 0);
        chk("arst_pc", int'(pc), 0);
        chk("arst_retired", int'(retired), 0);
        chk("arst_imem_req", int'(imem_req), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Three zero-wait ALU ops then halt
        for (int i = 0; i < 3; i++) prog_q.push_back(mk(3'd1, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 0, 0));
        prog_q.push_back(mk(3'd2, 1'b0, 1'b0, 1'b1, 6'd0, 8'd0, 0, 0));
        if (!aborted) run_prog();

        // Branch corner cases, including negative offset and PC wrap, halt at 7
        prog_q.push_back(mk(3'd3, 1'b1, 1'b0, 1'b0, 6'd0, 8'h05, 0, 0));
        prog_q.push_back(mk(3'd2, 1'b0, 1'b1, 1'b0, 6'b111110, 8'd0, 0, 0));
        prog_q.push_back(mk(3'd3, 1'b0, 1'b0, 1'b0, 6'd0, 8'h40, 1, 0));
        prog_q.push_back(mk(3'd3, 1'b1, 1'b0, 1'b0, 6'd0, 8'hFE, 0, 0));
        prog_q.push_back(mk(3'd2, 1'b0, 1'b1, 1'b0, 6'd4, 8'd0, 0, 0));
        prog_q.push_back(mk(3'd3, 1'b1, 1'b0, 1'b0, 6'd0, 8'h40, 0, 0));
        prog_q.push_back(mk(3'd3, 1'b1, 1'b0, 1'b0, 6'd0, 8'h07, 2, 0));
        prog_q.push_back(mk(3'd2, 1'b1, 1'b1, 1'b1, 6'd3, 8'd9, 0, 0));
        if (!aborted) run_prog();

        // Load with two wait cycles, store, slow-fetch load
        prog_q.push_back(mk(3'd6, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 0, 2));
        prog_q.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 0, 0));
        prog_q.push_back(mk(3'd6, 1'b0, 1'b0, 1'b0, 6'd0, 8'd0, 1, 0));
        prog_q.push_back(mk(3'd2, 1'b0, 1'b0, 1'b1, 6'd0, 8'd0, 0, 0));
        if (!aborted) run_prog();

        // Random programs
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++)
                prog_q.push_back(mk(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                                    1'($urandom_range(0, 1)), 1'b0, 6'($urandom),
                                    8'($urandom), $urandom_range(0, 3), $urandom_range(0, 3)));
            prog_q.push_back(mk(3'd2, 1'b0, 1'b0, 1'b1, 6'd0, 8'd0, $urandom_range(0, 2), 0));
            if (!aborted) run_prog();
        end

        repeat (2) @(posedge clk);
        #1 chk("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control FSM for the Cirno core. Owns the program counter and instruction register, fetches 9-bit instructions over a request/acknowledge port, and pulses the instruction decoder's enable. It then reads the decoder's registered outputs and sequences the ALU, register-file write, data-memory access and PC update for each instruction. It sits between instruction memory, the decoder, and the datapath, and is the only block that advances the PC.

## Interface
Parameters:
- PC_W, 8, program counter width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse; leaves IDLE/HALT and begins execution at PC 0
- imem_req  out  1  instruction fetch request; held until imem_ack
- imem_ack  in  1  fetch complete; imem_rdata valid in the same cycle
- imem_rdata  in  9  fetched instruction
- pc  out  PC_W  current program counter (fetch address)
- inst  out  9  instruction register; drives decoder inst
- decoder_en  out  1  one-cycle decode strobe
- inst_type  in  3  decoder class: 1 ALU, 2 imm-branch/NOP/halt, 3 reg-branch, 4 reg-move, 5 store, 6 load
- branch  in  1  decoder register-branch taken
- branchi  in  1  decoder immediate-branch taken
- immediate  in  6  decoder immediate (branch offset)
- done  in  1  decoder halt flag
- br_target  in  PC_W  register-file value for type-3 branches
- alu_en  out  1  ALU result strobe
- reg_wr_en  out  1  register-file write strobe
- dmem_req  out  1  data-memory request; held until dmem_ack
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req
- dmem_ack  in  1  data-memory complete
- halted  out  1  high in HALT
- retired  out  CNT_W  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, HALT.
- Reset values: state IDLE; pc 0; inst 0; retired 0; all strobes and requests 0; halted 0.
- IDLE: outputs quiet. On start: pc←0, retired←0, go to FETCH.
- FETCH: imem_req=1. On imem_ack: inst←imem_rdata, go to DECODE.
- DECODE: decoder_en=1 for exactly one cycle, then go to EXEC. Decoder outputs are registered, so they are sampled only in EXEC or MEM.
- EXEC, decided by inst_type:
  - 1: alu_en=1, reg_wr_en=1; pc←pc+1.
  - 4: reg_wr_en=1; pc←pc+1.
  - 2:
    - done=1: go to HALT; pc unchanged; not retired.
    - else branchi=1: pc←pc+sign_ext(immediate).
    - else pc←pc+1.
  - 3: pc←br_target if branch=1, else pc+1.
  - 5 and 6: go to MEM; pc unchanged in EXEC.
  - 0 and 7: NOP; pc←pc+1.
  - Every non-MEM, non-HALT exit returns to FETCH and does retired←retired+1.
- MEM: dmem_req=1; dmem_we=1 for type 5, 0 for type 6. On dmem_ack: pc←pc+1, retired+1, go to FETCH. For type 6 only, reg_wr_en=1 in the ack cycle.
- HALT: halted=1, outputs otherwise quiet. pc holds the halt instruction's address. start restarts exactly as from IDLE.
- Arithmetic:
  - PC arithmetic is modulo 2^PC_W; wrap-around from max to 0 is silent.
  - Branch offsets are sign-extended from 6 bits (−32..+31).
  - retired saturates at all-ones.
- start while running (FETCH/DECODE/EXEC/MEM) is ignored.
- rst_n low in any state forces the reset values immediately, including mid-fetch or mid-MEM; outstanding requests drop the same instant.

## Timing
- Strobes (decoder_en, alu_en, reg_wr_en) are registered-state decodes, high for exactly one cycle per instruction.
- imem_req and dmem_req:
  - Asserted from state entry.
  - Deasserted on the cycle after ack is seen; the ack cycle itself still shows req=1.
  - No new request is issued in the ack cycle.
- Latency with zero-wait memory (ack in the first req cycle):
  - ALU, move, branch, NOP: 3 cycles (FETCH, DECODE, EXEC).
  - Load/store: 4 cycles.
- Each wait cycle before an ack adds one cycle.
- pc and retired update on the same edge that leaves EXEC or MEM; the next FETCH presents the new pc.
- halted rises on the edge entering HALT.

## Test plan
- Reset mid-MEM: assert rst_n=0 while dmem_req=1 → dmem_req=0, pc=0, state IDLE asynchronously. After release, start → imem_req=1, pc=0.
- ALU sequence with ack in cycle 1: three inst_type=1 instructions → decoder_en, alu_en and reg_wr_en each pulse once per instruction, 3 cycles apart; pc 0→1→2→3; retired=3.
- Immediate branch: pc=5, inst_type=2, branchi=1, immediate=6'b111110 → pc=3. Also pc=8'hFE, immediate=6'd4 → pc=8'h02 (wrap).
- Load with 2 wait cycles: inst_type=6, dmem_ack on the 3rd req cycle → dmem_req high 3 cycles, dmem_we=0, reg_wr_en pulses in the ack cycle, pc+1, total latency 6 cycles.
- Halt: inst_type=2, done=1 at pc=7 → halted=1, pc=7, retired unchanged, no further imem_req. A start pulse → pc=0, retired=0, fetch resumes.
- Register branch: inst_type=3 with branch=1, br_target=8'h40 → pc=8'h40. With branch=0 → pc+1.
